// File: rtl/ram_result_reader_if.sv
// Signal bundle between ram_result_reader and its surroundings: start/config,
// the shared RAM read port, and the valid/ready output stream.
// Optional macro RESULT_CHECKSUM_EN adds the csum/csum_valid signals.
interface ram_result_reader_if #(
   parameter int AW = 3,
   parameter int DW = 8
);
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   count;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_rd_data;
   logic          busy;
   logic          done;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          out_valid;
   logic          out_ready;
`ifdef RESULT_CHECKSUM_EN
   logic [DW+AW-1:0] csum;
   logic             csum_valid;
`endif

   // Controller / RAM / downstream side
   modport master (
      output start, base_addr, count, ram_rd_data, out_ready,
      input  ram_addr, busy, done, out_data, out_addr, out_valid
`ifdef RESULT_CHECKSUM_EN
      , csum, csum_valid
`endif
   );

   // Reader side
   modport slave (
      input  start, base_addr, count, ram_rd_data, out_ready,
      output ram_addr, busy, done, out_data, out_addr, out_valid
`ifdef RESULT_CHECKSUM_EN
      , csum, csum_valid
`endif
   );
endinterface

// File: rtl/ram_result_reader.sv
// ram_result_reader: walks a window of result-RAM addresses (wrapping modulo
// 2**AW) and streams each word out over valid/ready, one word at a time.
// Optional macro RESULT_CHECKSUM_EN adds an unsigned sum of all handshaked
// words (csum) that is presented with csum_valid alongside done.
module ram_result_reader #(
   parameter int AW     = 3,
   parameter int DW     = 8,
   parameter int RD_LAT = 1   // RAM read latency, 1 or 2
) (
   input  logic               clk,
   input  logic               reset_n,
   ram_result_reader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HOLD,
      S_DONE
   } state_t;

   localparam logic [AW:0] MAX_COUNT = {1'b1, {AW{1'b0}}};
   // Wait counter start: number of extra WAIT cycles beyond the first.
   localparam logic        WAIT_INIT = (RD_LAT == 2) ? 1'b1 : 1'b0;

   state_t        state_q,     state_d;
   logic [AW-1:0] cur_q,       cur_d;
   logic [AW:0]   left_q,      left_d;
   logic          wait_q,      wait_d;
   logic [AW-1:0] ram_addr_q,  ram_addr_d;
   logic [DW-1:0] out_data_q,  out_data_d;
   logic [AW-1:0] out_addr_q,  out_addr_d;
   logic          out_valid_q, out_valid_d;
`ifdef RESULT_CHECKSUM_EN
   logic [DW+AW-1:0] csum_q, csum_d;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         left_q      <= '0;
         wait_q      <= 1'b0;
         ram_addr_q  <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_valid_q <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         // NOTE: non-blocking (<=) so every register samples pre-edge values.
         state_q     <= state_d;
         cur_q       <= cur_d;
         left_q      <= left_d;
         wait_q      <= wait_d;
         ram_addr_q  <= ram_addr_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_valid_q <= out_valid_d;
`ifdef RESULT_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   // Next-state and datapath update for the read walk.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path infers a latch.
      state_d     = state_q;
      cur_d       = cur_q;
      left_d      = left_q;
      wait_d      = wait_q;
      ram_addr_d  = ram_addr_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_valid_d = out_valid_q;
`ifdef RESULT_CHECKSUM_EN
      csum_d      = csum_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               cur_d  = bus.base_addr;
               left_d = (bus.count > MAX_COUNT) ? MAX_COUNT : bus.count;
`ifdef RESULT_CHECKSUM_EN
               csum_d = '0;
`endif
               if (bus.count == '0) begin
                  state_d = S_DONE;
               end else begin
                  // Address is registered on entry so it is driven throughout ISSUE.
                  ram_addr_d = bus.base_addr;
                  state_d    = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            wait_d  = WAIT_INIT;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (wait_q == 1'b0) begin
               out_data_d  = bus.ram_rd_data;
               out_addr_d  = cur_q;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end

         S_HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               left_d      = left_q - 1'b1;
               cur_d       = cur_q + 1'b1;
`ifdef RESULT_CHECKSUM_EN
               csum_d      = csum_q + {{AW{1'b0}}, out_data_q};
`endif
               if (left_q == {{AW{1'b0}}, 1'b1}) begin
                  // Last word: ram_addr keeps its value through DONE.
                  state_d = S_DONE;
               end else begin
                  ram_addr_d = cur_q + 1'b1;
                  state_d    = S_ISSUE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.ram_addr  = ram_addr_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
`ifdef RESULT_CHECKSUM_EN
   assign bus.csum       = csum_q;
   assign bus.csum_valid = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_ram_result_reader.sv
// Self-checking bench for ram_result_reader. A behavioural RAM supplies read
// data; expected streams are derived from the RAM contents, base and count.
module tb_ram_result_reader;
   localparam int AW     = 3;
   localparam int DW     = 8;
   localparam int RD_LAT = 1;
   localparam int DEPTH  = 1 << AW;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ram_result_reader_if #(.AW(AW), .DW(DW)) bus ();

   ram_result_reader #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Synchronous-read RAM with RD_LAT cycles of latency
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd1, rd2;
   always @(posedge clk) begin
      rd1 <= mem[bus.ram_addr];
      rd2 <= rd1;
   end
   assign bus.ram_rd_data = (RD_LAT == 2) ? rd2 : rd1;

   int checks = 0;
   int errors = 0;

   // Monitor: records each handshake and each done pulse (sampled mid-cycle)
   int obs_addr[$];
   int obs_data[$];
   int done_cnt = 0;
   always @(negedge clk) begin
      if (reset_n && bus.out_valid && bus.out_ready) begin
         obs_addr.push_back(int'(bus.out_addr));
         obs_data.push_back(int'(bus.out_data));
      end
      if (reset_n && bus.done) done_cnt++;
   end

   int obs_base;
   int done_base;

   function automatic int exp_len(input int c);
      return (c > DEPTH) ? DEPTH : c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
   endtask

   task automatic start_xfer(input int base, input int count);
      obs_base      = obs_addr.size();
      done_base     = done_cnt;
      bus.base_addr = base[AW-1:0];
      bus.count     = count[AW:0];
      bus.start     = 1'b1;
      step();
      bus.start     = 1'b0;
   endtask

   // Wait for done, then compare the recorded stream against the model
   task automatic finish_xfer(input string name, input int base, input int count,
                              input int budget, input bit rnd_ready);
      bit seen;
      int n;
      int sum;
      int got;
      n   = exp_len(count);
      sum = 0;
      for (int i = 0; i < n; i++) sum += int'(mem[(base + i) % DEPTH]);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
         step();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s done_timeout: no done within %0d cycles", name, budget);
      end
`ifdef RESULT_CHECKSUM_EN
      checks++;
      if (bus.csum_valid !== 1'b1 || int'(bus.csum) !== sum) begin
         errors++;
         $display("FAIL %s csum_at_done: got valid=%0b csum=0x%0h, expected valid=1 csum=0x%0h",
                  name, bus.csum_valid, bus.csum, sum);
      end
`endif
      bus.out_ready = 1'b1;
      step();
      checks++;
      if (done_cnt - done_base !== 1) begin
         errors++;
         $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt - done_base);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_after_done: got %0b, expected 0", name, bus.busy);
      end
`ifdef RESULT_CHECKSUM_EN
      checks++;
      if (bus.csum_valid !== 1'b0 || int'(bus.csum) !== sum) begin
         errors++;
         $display("FAIL %s csum_hold: got valid=%0b csum=0x%0h, expected valid=0 csum=0x%0h",
                  name, bus.csum_valid, bus.csum, sum);
      end
`endif
      got = obs_addr.size() - obs_base;
      checks++;
      if (got !== n) begin
         errors++;
         $display("FAIL %s word_count: got %0d, expected %0d", name, got, n);
      end
      for (int i = 0; i < n && i < got; i++) begin
         int a;
         a = (base + i) % DEPTH;
         checks++;
         if (obs_addr[obs_base + i] !== a || obs_data[obs_base + i] !== int'(mem[a])) begin
            errors++;
            $display("FAIL %s word%0d: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                     name, i, obs_addr[obs_base + i], obs_data[obs_base + i], a, mem[a]);
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.base_addr = '0; bus.count = '0; bus.out_ready = 1'b0;
      fill_random();
      reset_n = 1'b0;
      repeat (3) step();
      checks++;
      if (bus.ram_addr !== '0 || bus.out_data !== '0 || bus.out_addr !== '0 ||
          bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got addr=%0d data=%0h oaddr=%0d valid=%0b busy=%0b done=%0b, expected all 0",
                  bus.ram_addr, bus.out_data, bus.out_addr, bus.out_valid, bus.busy, bus.done);
      end
`ifdef RESULT_CHECKSUM_EN
      checks++;
      if (bus.csum !== '0 || bus.csum_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_csum: got csum=%0h valid=%0b, expected 0/0", bus.csum, bus.csum_valid);
      end
`endif
      @(negedge clk) reset_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int lat;
      fill_random();
      mem[1] = 8'h0C;
      mem[2] = 8'h31;
      bus.out_ready = 1'b1;
      start_xfer(1, 2);
      lat = 0;
      while (!bus.out_valid && lat < 10) begin
         step();
         lat++;
      end
      // start cycle -> first out_valid cycle is 2+RD_LAT; one of those edges is inside start_xfer
      checks++;
      if (lat !== (2 + RD_LAT) - 1) begin
         errors++;
         $display("FAIL basic_latency: got %0d cycles after accept, expected %0d", lat, (2 + RD_LAT) - 1);
      end
      finish_xfer("basic", 1, 2, 40, 1'b0);
   endtask

   task automatic test_backpressure();
      int base;
      int k;
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      fill_random();
      base = $urandom_range(0, DEPTH - 1);
      bus.out_ready = 1'b0;
      start_xfer(base, 3);
      k = 0;
      while (!bus.out_valid && k < 10) begin
         step();
         k++;
      end
      d = bus.out_data;
      a = bus.out_addr;
      checks++;
      if (bus.out_valid !== 1'b1 || int'(a) !== base || d !== mem[base]) begin
         errors++;
         $display("FAIL bp_first: got valid=%0b addr=%0d data=%0h, expected 1/%0d/%0h",
                  bus.out_valid, a, d, base, mem[base]);
      end
      for (int c = 0; c < 5; c++) begin
         step();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.out_addr !== a) begin
            errors++;
            $display("FAIL bp_stable%0d: got valid=%0b addr=%0d data=%0h, expected 1/%0d/%0h",
                     c, bus.out_valid, bus.out_addr, bus.out_data, a, d);
         end
      end
      bus.out_ready = 1'b1;
      finish_xfer("backpressure", base, 3, 40, 1'b0);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);
      bus.out_ready = 1'b1;
      start_xfer(6, 4);
      finish_xfer("wrap", 6, 4, 60, 1'b0);
   endtask

   task automatic test_count_limits();
      int base;
      fill_random();
      bus.out_ready = 1'b1;
      base = $urandom_range(0, DEPTH - 1);
      start_xfer(base, 0);
      finish_xfer("count0", base, 0, 2, 1'b0);
      base = $urandom_range(0, DEPTH - 1);
      start_xfer(base, DEPTH);
      finish_xfer("count_full", base, DEPTH, 100, 1'b0);
      base = $urandom_range(0, DEPTH - 1);
      start_xfer(base, DEPTH + 4);
      finish_xfer("count_sat", base, DEPTH + 4, 100, 1'b0);
   endtask

   task automatic test_reset_mid();
      int k;
      int dsnap;
      fill_random();
      bus.out_ready = 1'b0;
      start_xfer($urandom_range(0, DEPTH - 1), 4);
      k = 0;
      while (!bus.out_valid && k < 10) begin
         step();
         k++;
      end
      step();
      dsnap = done_cnt;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL midreset_immediate: got valid=%0b busy=%0b done=%0b, expected 0/0/0",
                  bus.out_valid, bus.busy, bus.done);
      end
      repeat (2) step();
      @(negedge clk) reset_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) step();
      checks++;
      if (done_cnt !== dsnap || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_no_done: got done_pulses=%0d busy=%0b, expected 0/0", done_cnt - dsnap, bus.busy);
      end
      start_xfer(0, 1);
      finish_xfer("after_reset", 0, 1, 40, 1'b0);
   endtask

   task automatic test_start_in_done();
      int base;
      bit seen;
      fill_random();
      bus.out_ready = 1'b1;
      base = $urandom_range(0, DEPTH - 1);
      start_xfer(base, 2);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL start_in_done_timeout: no done within 40 cycles");
      end
      bus.count = 4'd3;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_busy%0d: got %0b, expected 0", c, bus.busy);
         end
         step();
      end
      checks++;
      if (obs_addr.size() - obs_base !== 2 || done_cnt - done_base !== 1) begin
         errors++;
         $display("FAIL start_in_done_stream: got words=%0d dones=%0d, expected 2/1",
                  obs_addr.size() - obs_base, done_cnt - done_base);
      end
   endtask

   task automatic test_random();
      int base;
      int count;
      for (int t = 0; t < 8; t++) begin
         fill_random();
         base  = $urandom_range(0, DEPTH - 1);
         count = $urandom_range(0, DEPTH + 4);
         bus.out_ready = 1'($urandom_range(0, 1));
         start_xfer(base, count);
         finish_xfer($sformatf("random%0d", t), base, count, 300, 1'b1);
      end
   endtask

`ifdef RESULT_CHECKSUM_EN
   task automatic test_checksum();
      fill_random();
      mem[0] = 8'hFF;
      mem[1] = 8'hFF;
      mem[2] = 8'h01;
      mem[3] = 8'h10;
      bus.out_ready = 1'b1;
      start_xfer(0, 4);
      finish_xfer("checksum", 0, 4, 60, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_count_limits();
      test_reset_mid();
      test_start_in_done();
      test_random();
`ifdef RESULT_CHECKSUM_EN
      test_checksum();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
